// File: rtl/cond_writeback_stage.sv
// cond_writeback_stage
//   Execute-to-writeback stage sitting right after the ALU. Keeps the
//   architectural NZCV flags and checks each instruction's condition field
//   against them. It applies S-bit flag updates and registers one writeback
//   entry for the register file behind a valid/ready handshake.
//
// Ports
//   clk, nreset              clock, synchronous active-low reset
//   in_valid / in_ready      handshake from the ALU
//   cond, s_bit, logical_op  instruction control (condition, flag update, C/V hold)
//   rd_addr, alu_data        destination and ALU result
//   alu_carry, alu_overflow  ALU C and V outputs
//   alu_we                   instruction writes Rd
//   out_valid / out_ready    handshake to the register file
//   wb_addr, wb_data, wb_en  registered writeback entry
//   flags                    registered {N,Z,C,V}
//   carry_in                 registered C, returned to the ALU
//   exec_count               saturating count of accepted instructions that passed
//   squash_count             saturating count of accepted instructions that failed
module cond_writeback_stage #(
  parameter int REG_SIZE  = 32,
  parameter int ADDR_SIZE = 4,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           cond,
  input  logic                 s_bit,
  input  logic                 logical_op,
  input  logic [ADDR_SIZE-1:0] rd_addr,
  input  logic [REG_SIZE-1:0]  alu_data,
  input  logic                 alu_carry,
  input  logic                 alu_overflow,
  input  logic                 alu_we,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ADDR_SIZE-1:0] wb_addr,
  output logic [REG_SIZE-1:0]  wb_data,
  output logic                 wb_en,
  output logic [3:0]           flags,
  output logic                 carry_in,
  output logic [CNT_W-1:0]     exec_count,
  output logic [CNT_W-1:0]     squash_count
);

  logic accept;
  logic pass;
  logic f_n, f_z, f_c, f_v;

  assign f_n = flags[3];
  assign f_z = flags[2];
  assign f_c = flags[1];
  assign f_v = flags[0];

  // Single-entry buffer: a full entry can drain in the same cycle a new one lands.
  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  assign carry_in = flags[1];

  always_comb begin
    pass = 1'b0;
    case (cond)
      4'b0000: pass = f_z;
      4'b0001: pass = ~f_z;
      4'b0010: pass = f_c;
      4'b0011: pass = ~f_c;
      4'b0100: pass = f_n;
      4'b0101: pass = ~f_n;
      4'b0110: pass = f_v;
      4'b0111: pass = ~f_v;
      4'b1000: pass = f_c & ~f_z;
      4'b1001: pass = ~f_c | f_z;
      4'b1010: pass = (f_n == f_v);
      4'b1011: pass = (f_n != f_v);
      4'b1100: pass = ~f_z & (f_n == f_v);
      4'b1101: pass = f_z | (f_n != f_v);
      4'b1110: pass = 1'b1;
      default: pass = 1'b0;   // NV never executes
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      out_valid    <= 1'b0;
      wb_addr      <= '0;
      wb_data      <= '0;
      wb_en        <= 1'b0;
      flags        <= 4'b0000;
      exec_count   <= '0;
      squash_count <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      wb_addr   <= rd_addr;
      wb_data   <= alu_data;
      // A squashed instruction still yields an entry so register-file order is kept.
      wb_en     <= pass & alu_we;
      if (pass && s_bit) begin
        flags[3] <= alu_data[REG_SIZE-1];
        flags[2] <= (alu_data == '0);
        // Logical ops leave C and V alone.
        if (!logical_op) begin
          flags[1] <= alu_carry;
          flags[0] <= alu_overflow;
        end
      end
      if (pass) begin
        if (exec_count != '1) exec_count <= exec_count + CNT_W'(1);
      end else begin
        if (squash_count != '1) squash_count <= squash_count + CNT_W'(1);
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cond_writeback_stage.sv
module tb_cond_writeback_stage;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  cond = 4'd0;
  logic        s_bit = 1'b0;
  logic        logical_op = 1'b0;
  logic [3:0]  rd_addr = 4'd0;
  logic [31:0] alu_data = 32'd0;
  logic        alu_carry = 1'b0;
  logic        alu_overflow = 1'b0;
  logic        alu_we = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_en;
  logic [3:0]  flags;
  logic        carry_in;
  logic [15:0] exec_count;
  logic [15:0] squash_count;

  cond_writeback_stage dut (
    .clk(clk), .nreset(nreset), .in_valid(in_valid), .in_ready(in_ready),
    .cond(cond), .s_bit(s_bit), .logical_op(logical_op), .rd_addr(rd_addr),
    .alu_data(alu_data), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .alu_we(alu_we), .out_valid(out_valid), .out_ready(out_ready),
    .wb_addr(wb_addr), .wb_data(wb_data), .wb_en(wb_en), .flags(flags),
    .carry_in(carry_in), .exec_count(exec_count), .squash_count(squash_count)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model state
  logic [3:0]  m_flags;
  logic        m_valid;
  logic [3:0]  m_addr;
  logic [31:0] m_data;
  logic        m_en;
  int          m_exec;
  int          m_squash;

  // ARM conditions come in complementary pairs: cond[3:1] picks the base
  // test, cond[0] inverts it, except 1111 which never executes.
  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, r;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = cy;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cy && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: r = 1'b1;
    endcase
    if (c[0]) r = (c[3:1] == 3'd7) ? 1'b0 : !r;
    return r;
  endfunction

  task automatic model_reset();
    m_flags = 4'b0; m_valid = 1'b0; m_addr = 4'd0; m_data = 32'd0; m_en = 1'b0;
    m_exec = 0; m_squash = 0;
  endtask

  task automatic model_accept(input logic [3:0] c, input logic s, input logic lg,
                              input logic [3:0] rd, input logic [31:0] d,
                              input logic cy, input logic ov, input logic we);
    logic p;
    p = cond_ok(c, m_flags);
    m_valid = 1'b1; m_addr = rd; m_data = d; m_en = p & we;
    if (p && s) begin
      m_flags[3] = d[31];
      m_flags[2] = (d == 32'd0);
      if (!lg) m_flags[1:0] = {cy, ov};
    end
    if (p) m_exec = (m_exec == 65535) ? 65535 : m_exec + 1;
    else   m_squash = (m_squash == 65535) ? 65535 : m_squash + 1;
  endtask

  task automatic set_inputs(input logic [3:0] c, input logic s, input logic lg,
                            input logic [3:0] rd, input logic [31:0] d,
                            input logic cy, input logic ov, input logic we);
    cond = c; s_bit = s; logical_op = lg; rd_addr = rd; alu_data = d;
    alu_carry = cy; alu_overflow = ov; alu_we = we;
  endtask

  // One instruction, accepted on the next edge with out_ready high.
  task automatic issue(input logic [3:0] c, input logic s, input logic lg,
                       input logic [3:0] rd, input logic [31:0] d,
                       input logic cy, input logic ov, input logic we);
    set_inputs(c, s, lg, rd, d, cy, ov, we);
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    model_accept(c, s, lg, rd, d, cy, ov, we);
  endtask

  task automatic test_reset();
    nreset = 1'b0; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
    total++; if ({wb_addr, wb_data, wb_en} !== 37'd0) $display("FAIL reset_wb got %h/%h/%b want 0", wb_addr, wb_data, wb_en); else passed++;
    total++; if (flags !== 4'b0000) $display("FAIL reset_flags got %b want 0000", flags); else passed++;
    total++; if ({exec_count, squash_count} !== 32'd0) $display("FAIL reset_counts got %0d/%0d want 0/0", exec_count, squash_count); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
    nreset = 1'b1;
  endtask

  task automatic test_subs();
    issue(4'b1110, 1'b1, 1'b0, 4'd3, 32'd0, 1'b1, 1'b0, 1'b1);
    total++; if (wb_en !== 1'b1 || wb_addr !== 4'd3 || out_valid !== 1'b1) $display("FAIL subs_wb got en=%b addr=%0d v=%b want 1/3/1", wb_en, wb_addr, out_valid); else passed++;
    total++; if (flags !== 4'b0110) $display("FAIL subs_flags got %b want 0110", flags); else passed++;
    total++; if (exec_count !== 16'd1) $display("FAIL subs_exec got %0d want 1", exec_count); else passed++;
    total++; if (carry_in !== 1'b1) $display("FAIL subs_carry_in got %b want 1", carry_in); else passed++;
  endtask

  task automatic test_cmp_cond();
    issue(4'b1110, 1'b1, 1'b0, 4'd1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    total++; if (flags !== 4'b1001) $display("FAIL cmp_flags got %b want 1001", flags); else passed++;
    total++; if (wb_en !== 1'b0) $display("FAIL cmp_wb_en got %b want 0", wb_en); else passed++;
    issue(4'b0000, 1'b0, 1'b0, 4'd2, 32'h1234, 1'b0, 1'b0, 1'b1);
    total++; if (wb_en !== 1'b0 || out_valid !== 1'b1) $display("FAIL addeq_squash got en=%b v=%b want 0/1", wb_en, out_valid); else passed++;
    total++; if (squash_count !== 16'd1) $display("FAIL addeq_squash_count got %0d want 1", squash_count); else passed++;
    issue(4'b0100, 1'b0, 1'b0, 4'd2, 32'h5678, 1'b0, 1'b0, 1'b1);
    total++; if (wb_en !== 1'b1 || wb_data !== 32'h5678) $display("FAIL addmi got en=%b data=%h want 1/5678", wb_en, wb_data); else passed++;
  endtask

  task automatic test_logical_hold();
    issue(4'b1110, 1'b1, 1'b0, 4'd4, 32'd5, 1'b1, 1'b1, 1'b1);
    total++; if (flags !== 4'b0011) $display("FAIL adds_cv got %b want 0011", flags); else passed++;
    issue(4'b1110, 1'b1, 1'b1, 4'd5, 32'd0, 1'b0, 1'b0, 1'b1);
    total++; if (flags !== 4'b0111) $display("FAIL ands_hold got %b want 0111", flags); else passed++;
  endtask

  task automatic test_backpressure();
    logic [31:0] d;
    d = $urandom;
    set_inputs(4'b1110, 1'b1, 1'b0, 4'd9, d, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b1; out_ready = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready got %b want 0", in_ready); else passed++;
      total++; if (out_valid !== 1'b1 || wb_data !== m_data || wb_addr !== m_addr || wb_en !== m_en) $display("FAIL bp_stable got %h/%0d/%b want %h/%0d/%b", wb_data, wb_addr, wb_en, m_data, m_addr, m_en); else passed++;
      total++; if (flags !== m_flags) $display("FAIL bp_flags got %b want %b", flags, m_flags); else passed++;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    model_accept(4'b1110, 1'b1, 1'b0, 4'd9, d, 1'b0, 1'b0, 1'b1);
    total++; if (out_valid !== 1'b1 || wb_data !== d || wb_addr !== 4'd9) $display("FAIL bp_release got v=%b %h/%0d want 1 %h/9", out_valid, wb_data, wb_addr, d); else passed++;
    total++; if (flags !== m_flags) $display("FAIL bp_release_flags got %b want %b", flags, m_flags); else passed++;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0 || wb_data !== d) $display("FAIL drain got v=%b data=%h want 0/%h", out_valid, wb_data, d); else passed++;
  endtask

  // N=1,Z=1 cannot be produced by an ALU result, so those four flag
  // combinations are unreachable and skipped.
  task automatic test_cond_sweep();
    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < 16; c++) begin
        logic [3:0] fv;
        logic we;
        fv = 4'(f);
        if (fv[3] && fv[2]) continue;
        issue(4'b1110, 1'b1, 1'b0, 4'd0, fv[3] ? 32'h8000_0001 : (fv[2] ? 32'd0 : 32'd7), fv[1], fv[0], 1'b0);
        total++; if (flags !== fv) $display("FAIL sweep_setup got %b want %b", flags, fv); else passed++;
        we = 1'($urandom);
        issue(4'(c), 1'b0, 1'b0, 4'($urandom), $urandom, 1'b0, 1'b0, we);
        total++; if (wb_en !== m_en) $display("FAIL sweep cond=%b nzcv=%b got wb_en=%b want %b", 4'(c), fv, wb_en, m_en); else passed++;
      end
    end
    total++; if (exec_count !== 16'(m_exec) || squash_count !== 16'(m_squash)) $display("FAIL sweep_counts got %0d/%0d want %0d/%0d", exec_count, squash_count, m_exec, m_squash); else passed++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      issue(4'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
            ($urandom_range(3, 0) == 0) ? 32'd0 : $urandom,
            1'($urandom), 1'($urandom), 1'($urandom));
      total++; if (wb_en !== m_en || wb_addr !== m_addr || wb_data !== m_data || out_valid !== 1'b1) $display("FAIL rand_wb %0d got %b/%0d/%h want %b/%0d/%h", i, wb_en, wb_addr, wb_data, m_en, m_addr, m_data); else passed++;
      total++; if (flags !== m_flags || carry_in !== m_flags[1]) $display("FAIL rand_flags %0d got %b/%b want %b", i, flags, carry_in, m_flags); else passed++;
    end
    total++; if (exec_count !== 16'(m_exec) || squash_count !== 16'(m_squash)) $display("FAIL rand_counts got %0d/%0d want %0d/%0d", exec_count, squash_count, m_exec, m_squash); else passed++;
  endtask

  task automatic test_saturate_and_reset();
    int n;
    logic [15:0] ex;
    n = 65535 - m_squash + 2;
    ex = 16'(m_exec);
    set_inputs(4'b1111, 1'b1, 1'b0, 4'd6, 32'hdead_beef, 1'b1, 1'b1, 1'b1);
    in_valid = 1'b1; out_ready = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    in_valid = 1'b0;
    total++; if (squash_count !== 16'hFFFF) $display("FAIL squash_saturate got %h want ffff", squash_count); else passed++;
    total++; if (exec_count !== ex || wb_en !== 1'b0) $display("FAIL saturate_side got exec=%0d en=%b want %0d/0", exec_count, wb_en, ex); else passed++;
    total++; if (flags !== m_flags) $display("FAIL nv_flags got %b want %b", flags, m_flags); else passed++;
    out_ready = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b1 || in_ready !== 1'b0) $display("FAIL pre_reset_stall got v=%b r=%b want 1/0", out_valid, in_ready); else passed++;
    nreset = 1'b0;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) $display("FAIL midreset_out_valid got %b want 0", out_valid); else passed++;
    total++; if (flags !== 4'b0000) $display("FAIL midreset_flags got %b want 0000", flags); else passed++;
    total++; if (exec_count !== 16'd0 || squash_count !== 16'd0) $display("FAIL midreset_counts got %0d/%0d want 0/0", exec_count, squash_count); else passed++;
    in_valid = 1'b0; out_ready = 1'b1; nreset = 1'b1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_subs();
    test_cmp_cond();
    test_logical_hold();
    test_backpressure();
    test_cond_sweep();
    test_random();
    test_saturate_and_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
